// File: rtl/uart_xcvr_pkg.sv
// Shared state type and oversampling constants for the UART transceiver.
// UART_XCVR_PARITY_EN adds the PARITY state to both directions.
package uart_xcvr_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_MID      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_XCVR_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle o_tick every CLK_DIV clocks,
// phase realigned by i_restart so a bit period starts exactly on demand.
module uart_baud_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART with 16x oversampling, TX/RX valid-ready handshakes and
// sticky overrun. Define UART_XCVR_PARITY_EN to add a parity bit per frame.
module uart_xcvr
    import uart_xcvr_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int CLK_DIV    = 27,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] MID_TICK  = 4'(TICK_MID - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e          r_tx_state, w_tx_next;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [3:0]           r_tx_tcnt, r_tx_bcnt;
    logic                 w_tx_tick, w_tx_accept, w_tx_bit_end;

    uart_state_e          r_rx_state, w_rx_next;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [3:0]           r_rx_tcnt, r_rx_bcnt;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic                 w_rx_tick, w_rx_fall, w_rx_restart, w_rx_sample;
    logic                 w_rx_done, w_rx_load, w_par_bad;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_frame_err, r_parity_err, r_overrun;

    // ---------------- transmitter ----------------
    assign tx_ready     = (r_tx_state == S_IDLE) && !reset;
    assign w_tx_accept  = tx_valid && tx_ready;
    assign w_tx_bit_end = w_tx_tick && (r_tx_tcnt == LAST_TICK);

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_tx_baud (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_restart (w_tx_accept),
        .o_tick    (w_tx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_next;
    end

`ifdef UART_XCVR_PARITY_EN
    localparam logic PAR_SENSE = 1'(PARITY_ODD);
    logic r_tx_par, r_rx_par;

    always_ff @(posedge clk) begin
        if (w_tx_accept) r_tx_par <= ^tx_data ^ PAR_SENSE;
        if (w_rx_sample && r_rx_state == S_PARITY) r_rx_par <= r_rx_s2;
    end

    assign w_par_bad = r_rx_par != (^r_rx_shift ^ PAR_SENSE);
`else
    logic w_unused_parity;
    assign w_unused_parity = 1'(PARITY_ODD);
    assign w_par_bad       = 1'b0;
`endif

    always_comb begin
        w_tx_next = r_tx_state;
        tx        = 1'b1;
        case (r_tx_state)
            S_IDLE:  if (w_tx_accept) w_tx_next = S_START;
            S_START: begin
                tx = 1'b0;
                if (w_tx_bit_end) w_tx_next = S_DATA;
            end
            S_DATA: begin
                tx = r_tx_shift[0];
`ifdef UART_XCVR_PARITY_EN
                if (w_tx_bit_end && r_tx_bcnt == LAST_DATA) w_tx_next = S_PARITY;
            end
            S_PARITY: begin
                tx = r_tx_par;
                if (w_tx_bit_end) w_tx_next = S_STOP;
`else
                if (w_tx_bit_end && r_tx_bcnt == LAST_DATA) w_tx_next = S_STOP;
`endif
            end
            S_STOP:  if (w_tx_bit_end && r_tx_bcnt == LAST_STOP) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_accept) begin
            r_tx_shift <= tx_data;
        end else if (w_tx_bit_end && r_tx_state == S_DATA) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    // Bit counter restarts on every state change so it indexes within a state.
    always_ff @(posedge clk) begin
        if (reset || w_tx_accept) begin
            r_tx_tcnt <= '0;
            r_tx_bcnt <= '0;
        end else if (w_tx_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 4'd1;
            if (w_tx_bit_end) r_tx_bcnt <= (w_tx_next != r_tx_state) ? 4'd0 : r_tx_bcnt + 4'd1;
        end
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall    = r_rx_prev && !r_rx_s2;
    assign w_rx_restart = (r_rx_state == S_IDLE) && w_rx_fall;
    assign w_rx_sample  = w_rx_tick &&
                          (r_rx_tcnt == ((r_rx_state == S_START) ? MID_TICK : LAST_TICK));

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_rx_baud (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_restart (w_rx_restart),
        .o_tick    (w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_sample) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
`ifdef UART_XCVR_PARITY_EN
            S_DATA:   if (w_rx_sample && r_rx_bcnt == LAST_DATA) w_rx_next = S_PARITY;
            S_PARITY: if (w_rx_sample) w_rx_next = S_STOP;
`else
            S_DATA:   if (w_rx_sample && r_rx_bcnt == LAST_DATA) w_rx_next = S_STOP;
`endif
            S_STOP: if (w_rx_sample) begin
                w_rx_next = S_IDLE;
                w_rx_done = 1'b1;
            end
            default: w_rx_next = S_IDLE;
        endcase
    end

    // After the mid-start sample the tick counter realigns so later samples land mid-bit.
    always_ff @(posedge clk) begin
        if (reset || w_rx_restart || (w_rx_sample && r_rx_state == S_START)) begin
            r_rx_tcnt <= '0;
        end else if (w_rx_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
        end
        if (reset || w_rx_restart) begin
            r_rx_bcnt <= '0;
        end else if (w_rx_sample) begin
            r_rx_bcnt <= (w_rx_next != r_rx_state) ? 4'd0 : r_rx_bcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_sample && r_rx_state == S_DATA) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        end
    end

    assign w_rx_load = w_rx_done && (!r_rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_rx_load) begin
            r_rx_data    <= r_rx_shift;
            r_rx_valid   <= 1'b1;
            r_frame_err  <= !r_rx_s2;
            r_parity_err <= w_par_bad;
            r_overrun    <= 1'b0;
        end else if (w_rx_done) begin
            r_overrun    <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid   <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr (CLK_DIV=4, 8 data bits, 1 stop bit);
// builds the parity case too when UART_XCVR_PARITY_EN is defined.
module tb_uart_xcvr;

    localparam int DB = 8;
    localparam int SB = 1;
    localparam int CD = 4;
    localparam int PO = 0;
    localparam int BIT_CLKS = 16 * CD;
`ifdef UART_XCVR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int TX_BITS = 1 + DB + PB + SB;
    localparam int FRAME_CLKS = TX_BITS * BIT_CLKS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx;
    logic          rx;
    logic          rx_drv = 1'b1;
    logic          lb = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          frame_err, parity_err, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    logic fbits[$];

    assign rx = lb ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_xcvr #(
        .DATA_BITS (DB),
        .STOP_BITS (SB),
        .CLK_DIV   (CD),
        .PARITY_ODD(PO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    function automatic logic parity_of(input logic [DB-1:0] d);
        int ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return 1'((ones + PO) % 2);
    endfunction

    // Wire image of one frame, one entry per bit period; par < 0 means computed parity.
    function automatic void build_frame(input logic [DB-1:0] d, input int par,
                                        input logic stop_v, input int n_stop);
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < DB; i++) fbits.push_back(d[i]);
        if (PB == 1) fbits.push_back((par < 0) ? parity_of(d) : 1'(par));
        for (int i = 0; i < n_stop; i++) fbits.push_back((i == 0) ? stop_v : 1'b1);
    endfunction

    task automatic drive_rx(input logic [DB-1:0] d, input int par, input logic stop_v);
        build_frame(d, par, stop_v, 1);
        foreach (fbits[i]) begin
            rx_drv = fbits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; lb = 1'b0; rx_drv = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_tests++;
        if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        n_tests++;
        if ({rx_valid, rx_data, frame_err, parity_err, overrun} !== '0)
            begin n_fail++; $display("FAIL reset_rx_outputs: got v=%b d=%h fe=%b pe=%b ov=%b want all 0",
                                     rx_valid, rx_data, frame_err, parity_err, overrun); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_tx_frame(input logic [DB-1:0] d, input bit noise);
        int bad_bits = 0;
        int bad_rdy  = 0;
        build_frame(d, -1, 1'b1, SB);
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_idle_ready %h: got %b want 1", d, tx_ready); end
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= FRAME_CLKS; k++) begin
            @(negedge clk);
            if (k < FRAME_CLKS) begin
                if (tx !== fbits[k / BIT_CLKS]) bad_bits++;
                if (tx_ready !== 1'b0) bad_rdy++;
            end else begin
                n_tests++;
                if (tx_ready !== 1'b1)
                    begin n_fail++; $display("FAIL tx_ready_return %h: got %b want 1", d, tx_ready); end
            end
            if (noise && k < FRAME_CLKS - 2) begin
                tx_valid = 1'($urandom);
                tx_data  = DB'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
        end
        n_tests++;
        if (bad_bits != 0) begin n_fail++; $display("FAIL tx_bits %h: got %0d wrong cycles want 0", d, bad_bits); end
        n_tests++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL tx_busy_ready %h: got %0d cycles high want 0", d, bad_rdy); end
    endtask

    task automatic test_back_to_back(input int n);
        logic [DB-1:0] sent[$];
        logic [DB-1:0] got[$];
        int idx = 0;
        int flag_bad = 0;
        bit pend;
        for (int i = 0; i < n; i++)
            sent.push_back((i == 0) ? 8'h3C : (i == 1) ? 8'hC3 : DB'($urandom));
        lb = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        tx_data = sent[0]; tx_valid = 1'b1;
        pend = tx_ready;
        for (int c = 0; c < (n + 1) * FRAME_CLKS; c++) begin
            @(negedge clk);
            if (pend) begin
                idx++;
                if (idx < n) tx_data = sent[idx];
                else         tx_valid = 1'b0;
                pend = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                got.push_back(rx_data);
                if (frame_err || parity_err || overrun) flag_bad++;
            end
            if (tx_valid && tx_ready) pend = 1'b1;
        end
        tx_valid = 1'b0;
        n_tests++;
        if (got.size() != n) begin n_fail++; $display("FAIL lb_count: got %0d frames want %0d", got.size(), n); end
        for (int i = 0; i < n && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== sent[i]) begin n_fail++; $display("FAIL lb_data[%0d]: got %h want %h", i, got[i], sent[i]); end
        end
        n_tests++;
        if (flag_bad != 0) begin n_fail++; $display("FAIL lb_flags: got %0d flagged frames want 0", flag_bad); end
        lb = 1'b0;
    endtask

    task automatic test_false_start();
        int seen = 0;
        logic [DB-1:0] d;
        lb = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        for (int c = 0; c < 2 * FRAME_CLKS; c++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL false_start: got %0d valid cycles want 0", seen); end
        rx_ready = 1'b0;
        d = DB'($urandom);
        drive_rx(d, -1, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({rx_valid, rx_data, frame_err} !== {1'b1, d, 1'b0})
            begin n_fail++; $display("FAIL after_false_start: got v=%b d=%h fe=%b want v=1 d=%h fe=0",
                                     rx_valid, rx_data, frame_err, d); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_frame_err();
        logic [DB-1:0] d;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? 8'h55 : DB'($urandom);
            rx_ready = 1'b0;
            drive_rx(d, -1, 1'b0);
            repeat (4) @(negedge clk);
            n_tests++;
            if ({rx_valid, rx_data, frame_err, parity_err} !== {1'b1, d, 1'b1, 1'b0})
                begin n_fail++; $display("FAIL frame_err %h: got v=%b d=%h fe=%b pe=%b want v=1 d=%h fe=1 pe=0",
                                         d, rx_valid, rx_data, frame_err, parity_err, d); end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_overrun();
        logic [DB-1:0] d1, d2;
        for (int i = 0; i < 2; i++) begin
            d1 = (i == 0) ? 8'h11 : DB'($urandom);
            d2 = (i == 0) ? 8'h22 : ~d1;
            rx_ready = 1'b0;
            drive_rx(d1, -1, 1'b1);
            drive_rx(d2, -1, 1'b1);
            repeat (4) @(negedge clk);
            n_tests++;
            if ({rx_valid, rx_data, overrun, frame_err} !== {1'b1, d1, 1'b1, 1'b0})
                begin n_fail++; $display("FAIL overrun %h/%h: got v=%b d=%h ov=%b fe=%b want v=1 d=%h ov=1 fe=0",
                                         d1, d2, rx_valid, rx_data, overrun, frame_err, d1); end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            n_tests++;
            if ({rx_valid, overrun} !== 2'b00)
                begin n_fail++; $display("FAIL overrun_clear: got v=%b ov=%b want 0 0", rx_valid, overrun); end
        end
    endtask

    task automatic test_reset_midframe();
        int seen = 0;
        int tx_low = 0;
        lb = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        n_tests++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx: got %b want 0", tx); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({tx, tx_ready} !== 2'b10)
            begin n_fail++; $display("FAIL reset_abort: got tx=%b rdy=%b want tx=1 rdy=0", tx, tx_ready); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_release_ready: got %b want 1", tx_ready); end
        for (int c = 0; c < FRAME_CLKS; c++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) seen++;
            if (tx !== 1'b1) tx_low++;
        end
        n_tests++;
        if (seen != 0 || tx_low != 0)
            begin n_fail++; $display("FAIL abort_residue: got %0d valid and %0d tx-low cycles want 0 0", seen, tx_low); end
        lb = 1'b0;
    endtask

`ifdef UART_XCVR_PARITY_EN
    task automatic test_parity();
        logic [DB-1:0] d;
        rx_ready = 1'b0;
        drive_rx(8'h07, 0, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h07, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL parity_bad: got v=%b d=%h pe=%b fe=%b want v=1 d=07 pe=1 fe=0",
                                     rx_valid, rx_data, parity_err, frame_err); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        d = DB'($urandom);
        drive_rx(d, -1, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({rx_valid, rx_data, parity_err} !== {1'b1, d, 1'b0})
            begin n_fail++; $display("FAIL parity_good: got v=%b d=%h pe=%b want v=1 d=%h pe=0",
                                     rx_valid, rx_data, parity_err, d); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_tx_frame(8'hA5, 1'b0);
        test_tx_frame(DB'($urandom), 1'b1);
        test_tx_frame(DB'($urandom), 1'b1);
        test_back_to_back(5);
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
`ifdef UART_XCVR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, frame data width, legal 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, TX stop bits, legal 1 or 2.
REQ-003 SHALL have parameter CLK_DIV, default 27, clk cycles per 16x-oversample tick, legal >= 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only under UART_XCVR_PARITY_EN.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports tx_data (input, DATA_BITS), tx_valid (input, 1), tx_ready (output, 1): TX byte handshake.
REQ-008 SHALL have port tx, output, 1, serial line out, idle high.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line in, idle high.
REQ-010 SHALL have ports rx_data (output, DATA_BITS), rx_valid (output, 1), rx_ready (input, 1): RX holding-register handshake.
REQ-011 SHALL have outputs frame_err, parity_err, overrun, each 1 bit, qualified as below.

Function
REQ-012 Bit period SHALL be 16*CLK_DIV clk cycles; frame LSB-first: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
REQ-013 TX FSM states IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE.
REQ-014 Transfer on tx_valid&&tx_ready; tx_data latched that cycle; tx=0 from next cycle; TX divider restarts on accept.
REQ-015 Each TX bit SHALL hold exactly 16*CLK_DIV cycles; tx_ready returns 1 the cycle after last stop bit ends; back-to-back accept allowed that cycle.
REQ-016 tx_data/tx_valid changes while tx_ready=0 SHALL be ignored.
REQ-017 rx SHALL pass a 2-flop synchronizer; all RX decisions use synchronized value.
REQ-018 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized falling edge, RX divider restarted.
REQ-019 Start bit sampled at tick 8 (mid-bit); if 1, false start, return IDLE, no output.
REQ-020 Data/parity/stop bits sampled every 16 ticks after start sample; only first stop bit checked.
REQ-021 At stop sample: rx_data updated, rx_valid=1 next cycle, frame_err=(stop==0), parity_err per REQ-028; FSM to IDLE, ready for next start edge immediately.
REQ-022 rx_valid SHALL stay 1 until cycle after rx_valid&&rx_ready; frame_err/parity_err qualified by rx_valid.
REQ-023 Frame completing while rx_valid=1 and no rx_ready that cycle: rx_data/flags kept, new frame dropped, overrun=1 sticky until next accepted rx_ready; simultaneous completion and rx_ready SHALL load new frame, no overrun.

Reset
REQ-024 On reset: tx=1, tx_ready=0 during reset and 1 first cycle after, rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overrun=0, both FSMs IDLE, dividers cleared, synchronizer flops=1.
REQ-025 Reset mid-frame SHALL abort both directions; partial frames discarded, no rx_valid.

Configuration
REQ-026 Macro UART_XCVR_PARITY_EN SHALL compile parity in or out.
REQ-027 Without it: no PARITY state, frame omits parity bit, parity_err tied 0.
REQ-028 With it: TX sends XOR(data)^PARITY_ODD after data; RX sets parity_err when received bit differs from the same expression.

Structure
REQ-029 Package uart_xcvr_pkg SHALL hold TX/RX state enum typedef and tick-count constants (16, mid-sample 8).
REQ-030 Sub-module uart_baud_gen (CLK_DIV counter, restart input, one-cycle tick output) SHALL be instantiated twice, TX and RX.

Verification
REQ-031 CLK_DIV=4, DATA_BITS=8, no parity: send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 64 clk; tx_ready back after 640 clk.
REQ-032 Loopback tx->rx, send 0x3C then 0xC3 back-to-back, rx_ready=1 -> two rx_valid pulses, rx_data 0x3C then 0xC3, all flags 0.
REQ-033 rx low 20 clk then high (< 32-clk mid-sample) -> no rx_valid, RX FSM back in IDLE.
REQ-034 Frame 0x55 with stop bit driven 0 -> rx_valid=1, rx_data=0x55, frame_err=1.
REQ-035 Two frames 0x11, 0x22, rx_ready=0 -> rx_data stays 0x11, overrun=1; rx_ready pulse clears rx_valid and overrun.
REQ-036 PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit forced 0 -> parity_err=1; reset asserted mid-data-bit -> tx=1 next cycle, tx_ready=1 first cycle after release.
